// File: rtl/mult_param.sv
// Parametrised radix-2 Booth sequential multiplier with start/done handshake.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands finish in one cycle without asserting MultBusy.
module mult_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             MultInit,
  input  logic             MultSigned,
  input  logic [WIDTH-1:0] A_Out,
  input  logic [WIDTH-1:0] B_Out,
  output logic             MultBusy,
  output logic             MultStop,
  output logic [WIDTH-1:0] Mult_High_Out,
  output logic [WIDTH-1:0] Mult_Low_Out
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t multState, nextState;

  logic [WIDTH+1:0] accReg;
  logic [WIDTH:0]   mcandReg;
  logic [WIDTH:0]   mplierReg;
  logic             boothReg;
  logic [CW-1:0]    countReg;
  logic             bypassReg;

  logic [WIDTH:0]   aExt;
  logic [WIDTH:0]   bExt;
  logic [WIDTH+1:0] mcandWide;
  logic [WIDTH+1:0] sumVal;
  logic [WIDTH+1:0] accShift;
  logic [WIDTH:0]   mplierShift;
  logic             startOk;
  logic             lastIter;
  logic             zeroOp;

  assign aExt      = {MultSigned & A_Out[WIDTH-1], A_Out};
  assign bExt      = {MultSigned & B_Out[WIDTH-1], B_Out};
  assign mcandWide = {mcandReg[WIDTH], mcandReg};
  assign startOk   = MultInit && (multState != RUN);
  assign lastIter  = (multState == RUN) && (countReg == CW'(1));

`ifdef MULT_ZERO_BYPASS_EN
  assign zeroOp = (A_Out == '0) || (B_Out == '0);
`else
  assign zeroOp = 1'b0;
`endif

  // Booth step: add/subtract on {LSB, Booth bit}, then arithmetic shift of {acc, mplier, booth}
  always_comb begin
    sumVal = accReg;
    case ({mplierReg[0], boothReg})
      2'b01:   sumVal = accReg + mcandWide;
      2'b10:   sumVal = accReg - mcandWide;
      default: sumVal = accReg;
    endcase
    accShift    = {sumVal[WIDTH+1], sumVal[WIDTH+1:1]};
    mplierShift = {sumVal[0], mplierReg[WIDTH:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      multState <= IDLE;
    end else begin
      multState <= nextState;
    end
  end

  always_comb begin
    nextState = multState;
    MultBusy  = 1'b0;
    MultStop  = 1'b0;
    case (multState)
      IDLE: begin
        if (MultInit) nextState = RUN;
      end
      RUN: begin
        MultBusy = !bypassReg;
        if (countReg == CW'(1)) nextState = DONE;
      end
      DONE: begin
        MultStop = 1'b1;
        if (MultInit) nextState = RUN;
        else          nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // A bypassed zero operation runs a single silent iteration on zeroed operands
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      accReg        <= '0;
      mcandReg      <= '0;
      mplierReg     <= '0;
      boothReg      <= 1'b0;
      countReg      <= '0;
      bypassReg     <= 1'b0;
      Mult_High_Out <= '0;
      Mult_Low_Out  <= '0;
    end else if (startOk) begin
      accReg    <= '0;
      boothReg  <= 1'b0;
      bypassReg <= zeroOp;
      if (zeroOp) begin
        mcandReg  <= '0;
        mplierReg <= '0;
        countReg  <= CW'(1);
      end else begin
        mcandReg  <= aExt;
        mplierReg <= bExt;
        countReg  <= CW'(WIDTH + 1);
      end
    end else if (multState == RUN) begin
      accReg    <= accShift;
      mplierReg <= mplierShift;
      boothReg  <= mplierReg[0];
      countReg  <= countReg - CW'(1);
      if (lastIter) begin
        Mult_High_Out <= {accShift[WIDTH-2:0], mplierShift[WIDTH]};
        Mult_Low_Out  <= mplierShift[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mult_param.sv
// Directed self-checking bench for mult_param at WIDTH=32 (MULT_ZERO_BYPASS_EN aware).
module tb_mult_param;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             MultInit;
  logic             MultSigned;
  logic [WIDTH-1:0] A_Out;
  logic [WIDTH-1:0] B_Out;
  logic             MultBusy;
  logic             MultStop;
  logic [WIDTH-1:0] Mult_High_Out;
  logic [WIDTH-1:0] Mult_Low_Out;

  int checkCount = 0;
  int failCount  = 0;

  mult_param #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .MultInit      (MultInit),
    .MultSigned    (MultSigned),
    .A_Out         (A_Out),
    .B_Out         (B_Out),
    .MultBusy      (MultBusy),
    .MultStop      (MultStop),
    .Mult_High_Out (Mult_High_Out),
    .Mult_Low_Out  (Mult_Low_Out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until MultStop is seen, recording MultBusy on every sample before it
  task automatic waitStop(output int edges, output logic busyAll, output logic busyAny);
    edges   = 0;
    busyAll = 1'b1;
    busyAny = 1'b0;
    while (MultStop !== 1'b1 && edges < 200) begin
      busyAll = busyAll & (MultBusy === 1'b1);
      busyAny = busyAny | (MultBusy === 1'b1);
      tick();
      edges++;
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                               input logic keepInit, output int edges, output logic busyAll,
                               output logic busyAny);
    A_Out      = a;
    B_Out      = b;
    MultSigned = s;
    MultInit   = 1'b1;
    tick();
    MultInit   = keepInit;
    waitStop(edges, busyAll, busyAny);
  endtask

  initial begin
    int   edges;
    int   moreEdges;
    int   stopSeen;
    logic busyAll;
    logic busyAny;

    reset_n    = 1'b0;
    MultInit   = 1'b1;
    MultSigned = 1'b0;
    A_Out      = 32'd9;
    B_Out      = 32'd9;
    tick();
    tick();
    tick();
    checkOutput("reset busy", {63'd0, MultBusy}, 64'd0);
    checkOutput("reset stop", {63'd0, MultStop}, 64'd0);
    checkOutput("reset hi", {32'd0, Mult_High_Out}, 64'd0);
    checkOutput("reset lo", {32'd0, Mult_Low_Out}, 64'd0);
    reset_n  = 1'b1;
    MultInit = 1'b0;
    tick();
    checkOutput("init dropped at reset", {63'd0, MultBusy}, 64'd0);

    // 10 x 5 unsigned
    applyStimulus(32'd10, 32'd5, 1'b0, 1'b0, edges, busyAll, busyAny);
    checkOutput("basic latency", 64'(edges), 64'd33);
    checkOutput("basic busy throughout", {63'd0, busyAll}, 64'd1);
    checkOutput("basic busy at stop", {63'd0, MultBusy}, 64'd0);
    checkOutput("basic lo", {32'd0, Mult_Low_Out}, 64'd50);
    checkOutput("basic hi", {32'd0, Mult_High_Out}, 64'd0);
    tick();
    checkOutput("stop one cycle", {63'd0, MultStop}, 64'd0);
    checkOutput("result holds", {32'd0, Mult_Low_Out}, 64'd50);

    applyStimulus(32'hFFFFFFFD, 32'd7, 1'b1, 1'b0, edges, busyAll, busyAny);
    checkOutput("-3x7 hi", {32'd0, Mult_High_Out}, 64'hFFFFFFFF);
    checkOutput("-3x7 lo", {32'd0, Mult_Low_Out}, 64'hFFFFFFEB);

    applyStimulus(32'h80000000, 32'h80000000, 1'b1, 1'b0, edges, busyAll, busyAny);
    checkOutput("minneg sq hi", {32'd0, Mult_High_Out}, 64'h40000000);
    checkOutput("minneg sq lo", {32'd0, Mult_Low_Out}, 64'h0);

    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, edges, busyAll, busyAny);
    checkOutput("umax hi", {32'd0, Mult_High_Out}, 64'hFFFFFFFE);
    checkOutput("umax lo", {32'd0, Mult_Low_Out}, 64'h00000001);

    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, edges, busyAll, busyAny);
    checkOutput("smax hi", {32'd0, Mult_High_Out}, 64'h0);
    checkOutput("smax lo", {32'd0, Mult_Low_Out}, 64'h1);

    // MultInit with new operands in the middle of RUN must be ignored
    A_Out      = 32'd9;
    B_Out      = 32'd11;
    MultSigned = 1'b0;
    MultInit   = 1'b1;
    tick();
    MultInit = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    A_Out    = 32'd2;
    B_Out    = 32'd3;
    MultInit = 1'b1;
    tick();
    MultInit = 1'b0;
    waitStop(moreEdges, busyAll, busyAny);
    checkOutput("midrun latency", 64'(moreEdges + 6), 64'd33);
    checkOutput("midrun lo", {32'd0, Mult_Low_Out}, 64'd99);
    stopSeen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (MultStop === 1'b1) stopSeen++;
    end
    checkOutput("midrun single stop", 64'(stopSeen), 64'd0);

    // Held MultInit: DONE restarts at once with freshly sampled operands
    applyStimulus(32'd4, 32'd5, 1'b0, 1'b1, edges, busyAll, busyAny);
    checkOutput("held first latency", 64'(edges), 64'd33);
    checkOutput("held first lo", {32'd0, Mult_Low_Out}, 64'd20);
    A_Out = 32'd6;
    B_Out = 32'd9;
    tick();
    MultInit = 1'b0;
    checkOutput("held restart busy", {63'd0, MultBusy}, 64'd1);
    waitStop(edges, busyAll, busyAny);
    checkOutput("held second latency", 64'(edges), 64'd33);
    checkOutput("held second lo", {32'd0, Mult_Low_Out}, 64'd54);

    // Reset at cycle 10 of RUN
    A_Out      = 32'd123;
    B_Out      = 32'd456;
    MultInit   = 1'b1;
    tick();
    MultInit = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset_n = 1'b0;
    tick();
    checkOutput("midreset busy", {63'd0, MultBusy}, 64'd0);
    checkOutput("midreset stop", {63'd0, MultStop}, 64'd0);
    checkOutput("midreset hi", {32'd0, Mult_High_Out}, 64'd0);
    checkOutput("midreset lo", {32'd0, Mult_Low_Out}, 64'd0);
    reset_n  = 1'b1;
    stopSeen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (MultStop === 1'b1 || MultBusy === 1'b1) stopSeen++;
    end
    checkOutput("midreset quiet", 64'(stopSeen), 64'd0);
    applyStimulus(32'd6, 32'd7, 1'b0, 1'b0, edges, busyAll, busyAny);
    checkOutput("post-reset latency", 64'(edges), 64'd33);
    checkOutput("post-reset lo", {32'd0, Mult_Low_Out}, 64'd42);
    checkOutput("post-reset hi", {32'd0, Mult_High_Out}, 64'd0);

    // Zero operand
    applyStimulus(32'd0, 32'd123, 1'b0, 1'b0, edges, busyAll, busyAny);
`ifdef MULT_ZERO_BYPASS_EN
    checkOutput("zero latency", 64'(edges), 64'd1);
    checkOutput("zero busy never", {63'd0, busyAny}, 64'd0);
`else
    checkOutput("zero latency", 64'(edges), 64'd33);
    checkOutput("zero busy throughout", {63'd0, busyAll}, 64'd1);
`endif
    checkOutput("zero lo", {32'd0, Mult_Low_Out}, 64'd0);
    checkOutput("zero hi", {32'd0, Mult_High_Out}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
